alu_seq: RTL

//  Parametrised, handshaked successor to the combinational Hack ALU. Adds a registered

---
 rtl/alu_seq_pkg.sv | 20 ++
 rtl/alu_seq_if.sv | 26 ++
 rtl/hack_alu_core.sv | 22 ++
 rtl/alu_seq.sv | 133 +++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared constants for the sequenced ALU: mode codes, FSM state encodings
// and the common Hack control words.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    MODE_HACK = 2'b00,
    MODE_MUL  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_SAR  = 2'b11
  } alu_mode_e;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_MUL  = 2'b01;
  localparam logic [1:0] ST_HOLD = 2'b10;

  localparam logic [5:0] CTRL_ZERO    = 6'b101010;
  localparam logic [5:0] CTRL_XPLUSY  = 6'b000010;
  localparam logic [5:0] CTRL_XMINUSY = 6'b010011;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the decode stage (master) and the ALU (slave).
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [5:0]       ctrl;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zr;
  logic             ng;

  modport master (
    output in_valid, x, y, ctrl, mode, out_ready,
    input  in_ready, out_valid, out, zr, ng
  );

  modport slave (
    input  in_valid, x, y, ctrl, mode, out_ready,
    output in_ready, out_valid, out, zr, ng
  );
endinterface

// File: rtl/hack_alu_core.sv
// Combinational Hack ALU function at arbitrary width.
// ctrl = {zx, nx, zy, ny, f, no}.
module hack_alu_core #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic [5:0]       ctrl_i,
  output logic [WIDTH-1:0] res_o
);
  logic [WIDTH-1:0] xz, xn, yz, yn, fr;

  // zero/negate each operand, select add or and, optionally negate result
  always_comb begin
    xz    = ctrl_i[5] ? '0 : x_i;
    xn    = ctrl_i[4] ? ~xz : xz;
    yz    = ctrl_i[3] ? '0 : y_i;
    yn    = ctrl_i[2] ? ~yz : yz;
    fr    = ctrl_i[1] ? (xn + yn) : (xn & yn);
    res_o = ctrl_i[0] ? ~fr : fr;
  end
endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: Hack functions, shift-add multiply, shift left and
// arithmetic shift right, with a registered result held until consumed.
//
//  state | meaning
//  IDLE  | waiting for a request, in_ready=1
//  MUL   | shift-add multiply in progress, one step per cycle
//  HOLD  | result valid, held until out_ready
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input logic       clock,
  input logic       reset,
  alu_seq_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] CNT_LAST = (SHW + 1)'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zr_q, zr_d;
  logic             ng_q, ng_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [SHW:0]     cnt_q, cnt_d;

  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] hack_res;
  logic [WIDTH-1:0] quick_res;
  logic [WIDTH-1:0] mul_step;
  logic [SHW-1:0]   shamt;
  logic             out_we;

  hack_alu_core #(.WIDTH(WIDTH)) u_core (
    .x_i    (bus.x),
    .y_i    (bus.y),
    .ctrl_i (bus.ctrl),
    .res_o  (hack_res)
  );

  // handshake signals; in_ready deliberately has no path from in_valid
  assign in_ready = ~reset & ((state_q == ST_IDLE) |
                              ((state_q == ST_HOLD) & bus.out_ready));
  assign accept   = bus.in_valid & in_ready;
  assign shamt    = bus.y[SHW-1:0];

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.out       = out_q;
  assign bus.zr        = zr_q;
  assign bus.ng        = ng_q;

  // single-cycle results; MUL lands here only when the engine is disabled
  always_comb begin
    quick_res = '0;
    case (bus.mode)
      MODE_HACK: quick_res = hack_res;
      MODE_SHL:  quick_res = bus.x << shamt;
      MODE_SAR:  quick_res = WIDTH'($signed(bus.x) >>> shamt);
      default:   quick_res = '0;
    endcase
  end

  // one shift-add step: add the shifted multiplicand when the multiplier lsb is set
  assign mul_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    out_we   = 1'b0;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (state_q == ST_MUL) begin
      acc_d    = mul_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        out_d   = mul_step;
        out_we  = 1'b1;
        state_d = ST_HOLD;
      end
    end else if (accept) begin
      if ((bus.mode == MODE_MUL) && MUL_EN) begin
        acc_d    = '0;
        mcand_d  = bus.x;
        mplier_d = bus.y;
        cnt_d    = CNT_LAST;
        state_d  = ST_MUL;
      end else begin
        out_d   = quick_res;
        out_we  = 1'b1;
        state_d = ST_HOLD;
      end
    end else if (state_q == ST_HOLD) begin
      if (bus.out_ready) state_d = ST_IDLE;
    end else if (state_q != ST_IDLE) begin
      state_d = ST_IDLE;
    end
    zr_d = out_we ? (out_d == '0) : zr_q;
    ng_d = out_we ? out_d[WIDTH-1] : ng_q;
  end

  // state and datapath registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      out_q    <= '0;
      zr_q     <= 1'b0;
      ng_q     <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      zr_q     <= zr_d;
      ng_q     <= ng_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule
